// File: rtl/hyperram_arb_pkg.sv
// Shared types and constants for the two-port HyperRAM Avalon-MM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hyperram_arb_pkg;

    localparam int C_NUM_PORTS = 2;

    // IDLE    : no owner, both requesters stalled, arbitration happens here
    // WR      : owner's write burst forwarded, beats counted on acceptance
    // RD_CMD  : owner's read command forwarded until the controller takes it
    // RD_DATA : command path closed, read data counted back to the owner
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_CMD  = 2'd2,
        RD_DATA = 2'd3
    } state_t;

endpackage

// File: rtl/hyperram_arb_pick.sv
// Grant picker: chooses which requester wins the controller in IDLE.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only samples the result while idle.
//
// Ports:
//   req         in  : one request bit per port
//   last_grant  in  : port granted most recently (round-robin pointer)
//   grant_valid out : at least one port is requesting
//   grant_idx   out : winning port
//
// Build option HYPERRAM_ARB_FIXED_PRIO_EN: when defined, port 0 always wins a
// contest and last_grant is ignored; otherwise contests alternate.
module hyperram_arb_pick
    import hyperram_arb_pkg::*;
(
    input  logic [C_NUM_PORTS-1:0] req,
    input  logic                   last_grant,
    output logic                   grant_valid,
    output logic                   grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        if (req == 2'b10) begin
            grant_idx = 1'b1;
        end else if (req == 2'b11) begin
`ifdef HYPERRAM_ARB_FIXED_PRIO_EN
            grant_idx = 1'b0;
`else
            // Contest: hand the controller to whoever did not have it last.
            grant_idx = ~last_grant;
`endif
        end
    end

endmodule

// File: rtl/hyperram_avm_arbiter.sv
// Two-port Avalon-MM arbiter in front of the HyperRAM controller slave port.
// Latency: grant one edge after request; command/readdata paths combinational.
// Backpressure: owner sees the controller's waitrequest; non-owner always stalled.
//
// Ports:
//   clk_x1_i, rst_i            : controller clock, async active-high reset
//   sN_avm_*_i (N = 0, 1)      : requester command (write/read/address/data/be/burstcount)
//   sN_avm_readdata_o          : broadcast copy of controller read data
//   sN_avm_readdatavalid_o     : read data valid, owner only, RD_DATA only
//   sN_avm_waitrequest_o       : stall to requester N
//   m_avm_*_o                  : command to the controller (zero outside WR/RD_CMD)
//   m_avm_readdata_i/.._valid_i/waitrequest_i : controller response
//   err_o                      : sticky, readdatavalid seen outside RD_DATA
//
// Build option HYPERRAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0) on
// contention; default is round-robin.
module hyperram_avm_arbiter
    import hyperram_arb_pkg::*;
#(
    parameter int G_DATA_SIZE  = 16,
    parameter int G_ADDR_SIZE  = 32,
    parameter int G_BURST_SIZE = 8
) (
    input  logic                      clk_x1_i,
    input  logic                      rst_i,

    input  logic                      s0_avm_write_i,
    input  logic                      s0_avm_read_i,
    input  logic [G_ADDR_SIZE-1:0]    s0_avm_address_i,
    input  logic [G_DATA_SIZE-1:0]    s0_avm_writedata_i,
    input  logic [G_DATA_SIZE/8-1:0]  s0_avm_byteenable_i,
    input  logic [G_BURST_SIZE-1:0]   s0_avm_burstcount_i,
    output logic [G_DATA_SIZE-1:0]    s0_avm_readdata_o,
    output logic                      s0_avm_readdatavalid_o,
    output logic                      s0_avm_waitrequest_o,

    input  logic                      s1_avm_write_i,
    input  logic                      s1_avm_read_i,
    input  logic [G_ADDR_SIZE-1:0]    s1_avm_address_i,
    input  logic [G_DATA_SIZE-1:0]    s1_avm_writedata_i,
    input  logic [G_DATA_SIZE/8-1:0]  s1_avm_byteenable_i,
    input  logic [G_BURST_SIZE-1:0]   s1_avm_burstcount_i,
    output logic [G_DATA_SIZE-1:0]    s1_avm_readdata_o,
    output logic                      s1_avm_readdatavalid_o,
    output logic                      s1_avm_waitrequest_o,

    output logic                      m_avm_write_o,
    output logic                      m_avm_read_o,
    output logic [G_ADDR_SIZE-1:0]    m_avm_address_o,
    output logic [G_DATA_SIZE-1:0]    m_avm_writedata_o,
    output logic [G_DATA_SIZE/8-1:0]  m_avm_byteenable_o,
    output logic [G_BURST_SIZE-1:0]   m_avm_burstcount_o,
    input  logic [G_DATA_SIZE-1:0]    m_avm_readdata_i,
    input  logic                      m_avm_readdatavalid_i,
    input  logic                      m_avm_waitrequest_i,

    output logic                      err_o
);

    localparam logic [G_BURST_SIZE-1:0] C_ONE = G_BURST_SIZE'(1);

    state_t                   state, state_nxt;
    logic                     owner, owner_nxt;
    logic                     last_grant, last_grant_nxt;
    logic [G_BURST_SIZE-1:0]  beats, beats_nxt;
    logic                     err, err_nxt;

    logic [C_NUM_PORTS-1:0]   req;
    logic                     grant_valid;
    logic                     grant_idx;
    logic                     grant_write;
    logic [G_BURST_SIZE-1:0]  grant_bc;

    logic                     fwd;
    logic                     sel_write;
    logic                     sel_read;
    logic [G_ADDR_SIZE-1:0]   sel_address;
    logic [G_DATA_SIZE-1:0]   sel_writedata;
    logic [G_DATA_SIZE/8-1:0] sel_byteenable;
    logic [G_BURST_SIZE-1:0]  sel_burstcount;
    logic                     wr_accept;
    logic                     rd_accept;

    assign req[0] = s0_avm_write_i | s0_avm_read_i;
    assign req[1] = s1_avm_write_i | s1_avm_read_i;

    hyperram_arb_pick u_pick (
        .req         (req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Candidate's write flag and burst length, looked at only in IDLE.
    assign grant_write = grant_idx ? s1_avm_write_i      : s0_avm_write_i;
    assign grant_bc    = grant_idx ? s1_avm_burstcount_i : s0_avm_burstcount_i;

    // Owner's command, straight through with no register stage.
    assign sel_write      = owner ? s1_avm_write_i      : s0_avm_write_i;
    assign sel_read       = owner ? s1_avm_read_i       : s0_avm_read_i;
    assign sel_address    = owner ? s1_avm_address_i    : s0_avm_address_i;
    assign sel_writedata  = owner ? s1_avm_writedata_i  : s0_avm_writedata_i;
    assign sel_byteenable = owner ? s1_avm_byteenable_i : s0_avm_byteenable_i;
    assign sel_burstcount = owner ? s1_avm_burstcount_i : s0_avm_burstcount_i;

    // The command path is open only while a command is still being handed over;
    // in IDLE and RD_DATA everything toward the controller is held at zero.
    assign fwd = (state == WR) || (state == RD_CMD);

    assign m_avm_write_o      = fwd & sel_write;
    assign m_avm_read_o       = fwd & sel_read;
    assign m_avm_address_o    = fwd ? sel_address    : '0;
    assign m_avm_writedata_o  = fwd ? sel_writedata  : '0;
    assign m_avm_byteenable_o = fwd ? sel_byteenable : '0;
    assign m_avm_burstcount_o = fwd ? sel_burstcount : '0;

    assign s0_avm_waitrequest_o = (fwd && !owner) ? m_avm_waitrequest_i : 1'b1;
    assign s1_avm_waitrequest_o = (fwd &&  owner) ? m_avm_waitrequest_i : 1'b1;

    assign s0_avm_readdata_o = m_avm_readdata_i;
    assign s1_avm_readdata_o = m_avm_readdata_i;

    assign s0_avm_readdatavalid_o = (state == RD_DATA) && !owner && m_avm_readdatavalid_i;
    assign s1_avm_readdatavalid_o = (state == RD_DATA) &&  owner && m_avm_readdatavalid_i;

    assign err_o = err;

    assign wr_accept = m_avm_write_o & ~m_avm_waitrequest_i;
    assign rd_accept = m_avm_read_o  & ~m_avm_waitrequest_i;

    always_ff @(posedge clk_x1_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;   // port 0 wins the first contest
            beats      <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            beats      <= beats_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        beats_nxt      = beats;
        err_nxt        = err;

        // Read data nobody is waiting for is dropped and flagged.
        if (m_avm_readdatavalid_i && (state != RD_DATA)) begin
            err_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (grant_valid) begin
                    owner_nxt      = grant_idx;
                    last_grant_nxt = grant_idx;
                    // A zero burstcount still moves one beat.
                    beats_nxt      = (grant_bc == '0) ? C_ONE : grant_bc;
                    state_nxt      = grant_write ? WR : RD_CMD;
                end
            end
            WR: begin
                if (wr_accept) begin
                    beats_nxt = beats - C_ONE;
                    if (beats == C_ONE) begin
                        state_nxt = IDLE;
                    end
                end
            end
            RD_CMD: begin
                if (rd_accept) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_avm_readdatavalid_i) begin
                    beats_nxt = beats - C_ONE;
                    if (beats == C_ONE) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hyperram_avm_arbiter.sv
// Directed bench for the two-port HyperRAM Avalon-MM arbiter.
// Latency: n/a (bench).
// Backpressure: bench plays both requesters and the controller.
module tb_hyperram_avm_arbiter;

    typedef struct packed {
        logic        port;
        logic        rd;
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        logic [7:0]  bc;
    } cmd_t;

    typedef struct packed {
        logic        port;
        logic [15:0] d0;
        logic [15:0] d1;
    } rd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s0_write, s0_read, s1_write, s1_read;
    logic [31:0] s0_address, s1_address;
    logic [15:0] s0_writedata, s1_writedata;
    logic [1:0]  s0_byteenable, s1_byteenable;
    logic [7:0]  s0_burstcount, s1_burstcount;
    logic [15:0] s0_readdata, s1_readdata;
    logic        s0_rdv, s1_rdv, s0_wait, s1_wait;
    logic        m_write, m_read;
    logic [31:0] m_address;
    logic [15:0] m_writedata;
    logic [1:0]  m_byteenable;
    logic [7:0]  m_burstcount;
    logic [15:0] m_readdata;
    logic        m_rdv, m_wait;
    logic        err;

    int   checks = 0;
    int   failures = 0;
    cmd_t exp_cmd[$];
    rd_t  exp_rd[$];
    logic [4:0] wsch = 5'b00101;   // per-cycle waitrequest 1,0,1,0,0 (bit 0 first)
    int   stall [4] = '{2, 0, 1, 3};

    hyperram_avm_arbiter dut (
        .clk_x1_i               (clk),
        .rst_i                  (rst),
        .s0_avm_write_i         (s0_write),
        .s0_avm_read_i          (s0_read),
        .s0_avm_address_i       (s0_address),
        .s0_avm_writedata_i     (s0_writedata),
        .s0_avm_byteenable_i    (s0_byteenable),
        .s0_avm_burstcount_i    (s0_burstcount),
        .s0_avm_readdata_o      (s0_readdata),
        .s0_avm_readdatavalid_o (s0_rdv),
        .s0_avm_waitrequest_o   (s0_wait),
        .s1_avm_write_i         (s1_write),
        .s1_avm_read_i          (s1_read),
        .s1_avm_address_i       (s1_address),
        .s1_avm_writedata_i     (s1_writedata),
        .s1_avm_byteenable_i    (s1_byteenable),
        .s1_avm_burstcount_i    (s1_burstcount),
        .s1_avm_readdata_o      (s1_readdata),
        .s1_avm_readdatavalid_o (s1_rdv),
        .s1_avm_waitrequest_o   (s1_wait),
        .m_avm_write_o          (m_write),
        .m_avm_read_o           (m_read),
        .m_avm_address_o        (m_address),
        .m_avm_writedata_o      (m_writedata),
        .m_avm_byteenable_o     (m_byteenable),
        .m_avm_burstcount_o     (m_burstcount),
        .m_avm_readdata_i       (m_readdata),
        .m_avm_readdatavalid_i  (m_rdv),
        .m_avm_waitrequest_i    (m_wait),
        .err_o                  (err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] be_of(input int p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic wait_of(input int p);
        return (p == 0) ? s0_wait : s1_wait;
    endfunction

    task automatic drive(input int p, input logic wr, input logic rd, input logic [31:0] a,
                         input logic [15:0] d, input logic [7:0] bc);
        if (p == 0) begin
            s0_write = wr; s0_read = rd; s0_address = a; s0_writedata = d;
            s0_byteenable = (wr | rd) ? be_of(0) : 2'b00; s0_burstcount = bc;
        end else begin
            s1_write = wr; s1_read = rd; s1_address = a; s1_writedata = d;
            s1_byteenable = (wr | rd) ? be_of(1) : 2'b00; s1_burstcount = bc;
        end
    endtask

    task automatic push_cmd(input int p, input logic rd, input logic [31:0] a,
                            input logic [15:0] d, input logic [7:0] bc);
        cmd_t c;
        c.port = (p != 0); c.rd = rd; c.addr = a; c.data = d; c.be = be_of(p); c.bc = bc;
        exp_cmd.push_back(c);
    endtask

    task automatic push_rd(input int p, input logic [15:0] d);
        rd_t r;
        r.port = (p != 0); r.d0 = d; r.d1 = d;
        exp_rd.push_back(r);
    endtask

    // Hold the command until this port's waitrequest drops, then let one edge accept it.
    task automatic wait_accept(input int p);
        int k = 0;
        #1;
        while (wait_of(p) && k < 40) begin
            tick();
            k++;
        end
        check($sformatf("accept_p%0d", p), 64'(wait_of(p)), 64'd0);
        tick();
    endtask

    task automatic wr_seq(input int p, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            drive(p, 1'b1, 1'b0, base + 32'(i), 16'hA000 + 16'(p * 256 + i), 8'd1);
            wait_accept(p);
        end
        drive(p, 1'b0, 1'b0, 32'd0, 16'd0, 8'd0);
    endtask

    // Scoreboard: every accepted command and every read-data pulse pops one entry.
    always @(negedge clk) begin
        cmd_t ce, co;
        rd_t  re, ro;
        if (!rst) begin
            if ((m_write || m_read) && !m_wait) begin
                if (exp_cmd.size() != 0) ce = exp_cmd.pop_front();
                else ce = '1;
                co.port = !s1_wait;
                co.rd   = m_read;
                co.addr = m_address;
                co.data = m_read ? 16'd0 : m_writedata;
                co.be   = m_byteenable;
                co.bc   = m_burstcount;
                check("cmd", 64'(co), 64'(ce));
            end
            if (s0_rdv || s1_rdv) begin
                if (exp_rd.size() != 0) re = exp_rd.pop_front();
                else re = '1;
                ro.port = s1_rdv;
                ro.d0   = s0_readdata;
                ro.d1   = s1_readdata;
                check("rdv", 64'(ro), 64'(re));
                check("rdv_exclusive", 64'(s0_rdv & s1_rdv), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nb;
        logic acc;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 16'd0, 8'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 16'd0, 8'd0);
        m_readdata = 16'd0; m_rdv = 1'b0; m_wait = 1'b0;

        // Reset values
        #12;
        check("rst_m_write", 64'(m_write), 64'd0);
        check("rst_m_read", 64'(m_read), 64'd0);
        check("rst_m_addr", 64'(m_address), 64'd0);
        check("rst_s0_wait", 64'(s0_wait), 64'd1);
        check("rst_s1_wait", 64'(s1_wait), 64'd1);
        check("rst_rdv", 64'({s0_rdv, s1_rdv}), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        tick();

        // 1: single write from port 0
        push_cmd(0, 1'b0, 32'h10, 16'hA5A5, 8'd1);
        drive(0, 1'b1, 1'b0, 32'h10, 16'hA5A5, 8'd1);
        #1;
        check("t1_idle_no_write", 64'(m_write), 64'd0);
        tick();
        check("t1_write_fwd", 64'(m_write), 64'd1);
        check("t1_addr", 64'(m_address), 64'h10);
        check("t1_s0_wait", 64'(s0_wait), 64'd0);
        check("t1_s1_wait", 64'(s1_wait), 64'd1);
        tick();
        drive(0, 1'b0, 1'b0, 32'd0, 16'd0, 8'd0);
        #1;
        check("t1_back_idle", 64'(m_write), 64'd0);
        check("t1_s0_wait_idle", 64'(s0_wait), 64'd1);
        check("t1_s1_wait_idle", 64'(s1_wait), 64'd1);

        // 2: contention, both ports with two single writes each
        rst = 1'b1; tick(); rst = 1'b0;
`ifdef HYPERRAM_ARB_FIXED_PRIO_EN
        push_cmd(0, 1'b0, 32'h100, 16'hA000, 8'd1);
        push_cmd(0, 1'b0, 32'h101, 16'hA001, 8'd1);
        push_cmd(1, 1'b0, 32'h180, 16'hA100, 8'd1);
        push_cmd(1, 1'b0, 32'h181, 16'hA101, 8'd1);
`else
        push_cmd(0, 1'b0, 32'h100, 16'hA000, 8'd1);
        push_cmd(1, 1'b0, 32'h180, 16'hA100, 8'd1);
        push_cmd(0, 1'b0, 32'h101, 16'hA001, 8'd1);
        push_cmd(1, 1'b0, 32'h181, 16'hA101, 8'd1);
`endif
        fork
            wr_seq(0, 2, 32'h100);
            wr_seq(1, 2, 32'h180);
        join

        // 3: port 1 read burst of 4, port 0 write waits for the last valid
        push_cmd(1, 1'b1, 32'h200, 16'd0, 8'd4);
        drive(1, 1'b0, 1'b1, 32'h200, 16'd0, 8'd4);
        tick();
        push_cmd(0, 1'b0, 32'h300, 16'h1234, 8'd1);
        drive(0, 1'b1, 1'b0, 32'h300, 16'h1234, 8'd1);
        #1;
        check("t3_rd_grant_p1", 64'(s1_wait), 64'd0);
        tick();
        drive(1, 1'b0, 1'b0, 32'd0, 16'd0, 8'd0);
        #1;
        check("t3_rddata_m_read", 64'(m_read), 64'd0);
        check("t3_rddata_s1_wait", 64'(s1_wait), 64'd1);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < stall[k]; j++) begin
                check("t3_p0_blocked", 64'(s0_wait), 64'd1);
                check("t3_no_write", 64'(m_write), 64'd0);
                tick();
            end
            push_rd(1, 16'hD000 + 16'(k));
            m_readdata = 16'hD000 + 16'(k);
            m_rdv = 1'b1;
            #1;
            check("t3_p0_rdv_quiet", 64'(s0_rdv), 64'd0);
            check("t3_p0_blocked_v", 64'(s0_wait), 64'd1);
            tick();
            m_rdv = 1'b0;
        end
        wait_accept(0);
        drive(0, 1'b0, 1'b0, 32'd0, 16'd0, 8'd0);

        // 4: write burst of 3 under waitrequest 1,0,1,0,0
        m_wait = 1'b1;
        for (int i = 0; i < 3; i++) push_cmd(0, 1'b0, 32'h400, 16'hB000 + 16'(i), 8'd3);
        drive(0, 1'b1, 1'b0, 32'h400, 16'hB000, 8'd3);
        tick();
        nb = 0;
        for (int i = 0; i < 5; i++) begin
            m_wait = wsch[i];
            #1;
            acc = !s0_wait;
            tick();
            if (acc) begin
                nb++;
                if (nb < 3) drive(0, 1'b1, 1'b0, 32'h400, 16'hB000 + 16'(nb), 8'd3);
                else        drive(0, 1'b0, 1'b0, 32'd0, 16'd0, 8'd0);
            end
        end
        check("t4_beats", 64'(nb), 64'd3);
        m_wait = 1'b0;
        #1;
        check("t4_idle", 64'(s0_wait), 64'd1);
        tick();

        // 5: asynchronous reset in RD_DATA
        push_cmd(1, 1'b1, 32'h500, 16'd0, 8'd2);
        drive(1, 1'b0, 1'b1, 32'h500, 16'd0, 8'd2);
        tick();
        check("t5_rd_grant", 64'(s1_wait), 64'd0);
        tick();
        drive(1, 1'b0, 1'b0, 32'd0, 16'd0, 8'd0);
        push_rd(1, 16'hE000);
        m_readdata = 16'hE000;
        m_rdv = 1'b1;
        tick();
        m_rdv = 1'b0;
        push_cmd(0, 1'b0, 32'h600, 16'hC0DE, 8'd1);
        rst = 1'b1;
        #1;
        m_rdv = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h600, 16'hC0DE, 8'd1);
        drive(1, 1'b0, 1'b1, 32'h700, 16'd0, 8'd1);
        #1;
        check("t5_rst_s1_rdv", 64'(s1_rdv), 64'd0);
        check("t5_rst_s0_rdv", 64'(s0_rdv), 64'd0);
        check("t5_rst_waits", 64'({s0_wait, s1_wait}), 64'd3);
        check("t5_rst_cmd", 64'({m_write, m_read}), 64'd0);
        check("t5_rst_addr", 64'(m_address), 64'd0);
        check("t5_rst_err", 64'(err), 64'd0);
        m_rdv = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        check("t5_grant_p0", 64'(s0_wait), 64'd0);
        check("t5_p1_held", 64'(s1_wait), 64'd1);
        tick();
        drive(0, 1'b0, 1'b0, 32'd0, 16'd0, 8'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 16'd0, 8'd0);
        tick();

        // 6: stray readdatavalid in IDLE
        check("t6_err_before", 64'(err), 64'd0);
        m_readdata = 16'hBAD0;
        m_rdv = 1'b1;
        #1;
        check("t6_no_rdv", 64'({s0_rdv, s1_rdv}), 64'd0);
        tick();
        m_rdv = 1'b0;
        #1;
        check("t6_err_set", 64'(err), 64'd1);
        tick();
        tick();
        check("t6_err_sticky", 64'(err), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_err_cleared", 64'(err), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        check("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
        check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
